// File: rtl/inst_encoder_writer.sv
// Packs RISC-V instruction fields into 32-bit words and streams them into IMEM.
// Define INST_ENCODER_IMM_CHECK_EN to compile in immediate range checking on err.
module inst_encoder_writer #(
  parameter int ADDR_WIDTH = 14,
  parameter int START_ADDR = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  clear,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [2:0]            fmt,
  input  logic [6:0]            opcode,
  input  logic [2:0]            funct3,
  input  logic [6:0]            funct7,
  input  logic [4:0]            rd,
  input  logic [4:0]            rs1,
  input  logic [4:0]            rs2,
  input  logic [31:0]           imm,
  output logic                  imem_we,
  input  logic                  imem_ready,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  output logic [31:0]           imem_din,
  output logic [ADDR_WIDTH:0]   words_written,
  output logic                  err
);

  localparam logic [ADDR_WIDTH-1:0] START_A = ADDR_WIDTH'(START_ADDR);
  localparam logic [ADDR_WIDTH-1:0] LAST_A  = '1;
  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = ADDR_WIDTH'(1);
  localparam logic [ADDR_WIDTH:0]   CNT_ONE  = (ADDR_WIDTH + 1)'(1);

  localparam logic [2:0] FMT_R = 3'd0;
  localparam logic [2:0] FMT_I = 3'd1;
  localparam logic [2:0] FMT_S = 3'd2;
  localparam logic [2:0] FMT_B = 3'd3;
  localparam logic [2:0] FMT_U = 3'd4;
  localparam logic [2:0] FMT_J = 3'd5;

  localparam logic [31:0] NOP_WORD = 32'h0000_0013;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    FULL   = 2'd2
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic                  r_we;
  logic [31:0]           r_din;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [ADDR_WIDTH:0]   r_count;

  logic        w_ready;
  logic        w_fire;
  logic        w_accept;
  logic        w_start;
  logic        w_at_last;
  logic [31:0] w_word;

  assign w_fire    = r_we && imem_ready;
  assign w_at_last = (r_addr == LAST_A);
  assign w_start   = (r_state == IDLE) && start && !clear;
  assign in_ready  = w_ready && rst;
  assign w_accept  = in_valid && in_ready;

  // Gating with rst keeps IMEM from completing a write in a reset cycle.
  assign imem_we       = r_we && rst;
  assign imem_din      = r_din;
  assign imem_addr     = r_addr;
  assign words_written = r_count;

  always_comb begin
    // NOTE: defaults first so every path assigns each output and no latch is inferred.
    w_word = NOP_WORD;
    case (fmt)
      FMT_R: w_word = {funct7, rs2, rs1, funct3, rd, opcode};
      FMT_I: w_word = {imm[11:0], rs1, funct3, rd, opcode};
      FMT_S: w_word = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
      FMT_B: w_word = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
      FMT_U: w_word = {imm[31:12], rd, opcode};
      FMT_J: w_word = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
      default: w_word = NOP_WORD;
    endcase
  end

  // A request is refused once the word for the last address is already pending,
  // so the stream never runs past the top of IMEM.
  always_comb begin
    w_state_nxt = r_state;
    w_ready     = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) w_state_nxt = STREAM;
      end
      STREAM: begin
        w_ready = !r_we || (imem_ready && !w_at_last);
        if (w_fire && w_at_last) w_state_nxt = FULL;
      end
      FULL: begin
        w_state_nxt = FULL;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
    if (clear) begin
      w_state_nxt = IDLE;
      w_ready     = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state is updated with non-blocking assignments only.
    if (!rst) r_state <= IDLE;
    else      r_state <= w_state_nxt;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_we    <= 1'b0;
      r_din   <= '0;
      r_addr  <= START_A;
      r_count <= '0;
    end else begin
      if (clear)         r_we <= 1'b0;
      else if (w_accept) r_we <= 1'b1;
      else if (w_fire)   r_we <= 1'b0;

      if (w_accept) r_din <= w_word;

      if (w_start) begin
        r_addr  <= START_A;
        r_count <= '0;
      end else if (w_fire && !clear) begin
        if (!w_at_last) r_addr <= r_addr + ADDR_ONE;
        r_count <= r_count + CNT_ONE;
      end
    end
  end

`ifdef INST_ENCODER_IMM_CHECK_EN
  logic               r_err;
  logic               w_imm_bad;
  logic signed [31:0] w_imm_s;

  assign w_imm_s = $signed(imm);

  always_comb begin
    w_imm_bad = 1'b0;
    case (fmt)
      FMT_R:        w_imm_bad = 1'b0;
      FMT_I, FMT_S: w_imm_bad = (w_imm_s < -32'sd2048) || (w_imm_s > 32'sd2047);
      FMT_B:        w_imm_bad = (w_imm_s < -32'sd4096) || (w_imm_s > 32'sd4094) || imm[0];
      FMT_U:        w_imm_bad = (imm[11:0] != 12'd0);
      FMT_J:        w_imm_bad = (w_imm_s < -32'sd1048576) || (w_imm_s > 32'sd1048574) || imm[0];
      default:      w_imm_bad = 1'b1;
    endcase
  end

  // Sticky until the next start; clear alone does not wipe the error.
  always_ff @(posedge clk) begin
    if (!rst)                        r_err <= 1'b0;
    else if (w_start)                r_err <= 1'b0;
    else if (w_accept && w_imm_bad)  r_err <= 1'b1;
  end

  assign err = r_err;
`else
  assign err = 1'b0;
`endif

endmodule
